// File: rtl/sha256_job_arbiter_if.sv
// Requester and core-side signals of the SHA-256 job arbiter.
// The master modport is the arbiter; the slave modport is the requesters plus the core.
interface sha256_job_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]     req;
   logic [NUM_REQ*512-1:0] req_block;
   logic [NUM_REQ*256-1:0] req_seed;
   logic [NUM_REQ-1:0]     req_ack;
   logic [NUM_REQ-1:0]     rsp_valid;
   logic [NUM_REQ-1:0]     rsp_ready;
   logic [255:0]           rsp_digest;
   logic                   rsp_error;
   logic                   core_start;
   logic [255:0]           core_seed;
   logic [511:0]           core_block;
   logic                   core_done;
   logic [255:0]           core_digest;

   modport master (
      input  req, req_block, req_seed, rsp_ready, core_done, core_digest,
      output req_ack, rsp_valid, rsp_digest, rsp_error, core_start, core_seed, core_block
   );

   modport slave (
      output req, req_block, req_seed, rsp_ready, core_done, core_digest,
      input  req_ack, rsp_valid, rsp_digest, rsp_error, core_start, core_seed, core_block
   );
endinterface

// File: rtl/sha256_job_arbiter.sv
// Round-robin arbiter sharing one SHA-256 compression core between NUM_REQ requesters,
// with a watchdog that aborts jobs the core never finishes.
module sha256_job_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input logic                  clk,
   input logic                  reset_n,
   sha256_job_arbiter_if.master bus
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TW-1:0] TIMER_LIMIT = TW'(TIMEOUT_CYCLES);
   localparam logic [IW-1:0] LAST_REQ    = IW'(NUM_REQ - 1);

   typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESPOND} state_t;

   state_t          state;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   grant_id;
   logic [IW-1:0]   grant_sel;
   logic            grant_found;
   logic [TW-1:0]   timer;

   // First requesting index found by walking forward from rr_ptr with wrap-around.
   always_comb begin
      logic [IW:0] pos;
      grant_found = 1'b0;
      grant_sel   = '0;
      pos         = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         pos = {1'b0, rr_ptr} + (IW+1)'(i);
         if (pos >= (IW+1)'(NUM_REQ)) pos = pos - (IW+1)'(NUM_REQ);
         if (!grant_found && bus.req[pos[IW-1:0]]) begin
            grant_found = 1'b1;
            grant_sel   = pos[IW-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         rr_ptr         <= '0;
         grant_id       <= '0;
         timer          <= '0;
         bus.req_ack    <= '0;
         bus.rsp_valid  <= '0;
         bus.rsp_error  <= 1'b0;
         bus.rsp_digest <= '0;
         bus.core_start <= 1'b0;
         bus.core_seed  <= '0;
         bus.core_block <= '0;
      end else begin
         bus.req_ack    <= '0;
         bus.core_start <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_found) begin
                  bus.core_block <= bus.req_block[grant_sel*512 +: 512];
                  bus.core_seed  <= bus.req_seed[grant_sel*256 +: 256];
                  bus.req_ack    <= NUM_REQ'(1) << grant_sel;
                  grant_id       <= grant_sel;
                  state          <= LAUNCH;
               end
            end
            LAUNCH: begin
               bus.core_start <= 1'b1;
               timer          <= '0;
               state          <= WAIT_BUSY;
            end
            // The watchdog limit is checked before the busy transition, so timer never exceeds it.
            WAIT_BUSY: begin
               if (timer >= TIMER_LIMIT) begin
                  bus.rsp_digest <= '0;
                  bus.rsp_error  <= 1'b1;
                  bus.rsp_valid  <= NUM_REQ'(1) << grant_id;
                  state          <= RESPOND;
               end else begin
                  timer <= timer + 1'b1;
                  if (!bus.core_done) state <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (bus.core_done) begin
                  bus.rsp_digest <= bus.core_digest;
                  bus.rsp_error  <= 1'b0;
                  bus.rsp_valid  <= NUM_REQ'(1) << grant_id;
                  state          <= RESPOND;
               end else if (timer >= TIMER_LIMIT) begin
                  bus.rsp_digest <= '0;
                  bus.rsp_error  <= 1'b1;
                  bus.rsp_valid  <= NUM_REQ'(1) << grant_id;
                  state          <= RESPOND;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            RESPOND: begin
               if (bus.rsp_ready[grant_id]) begin
                  bus.rsp_valid <= '0;
                  bus.rsp_error <= 1'b0;
                  rr_ptr        <= (grant_id == LAST_REQ) ? '0 : grant_id + 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sha256_job_arbiter.sv
// Self-checking bench for sha256_job_arbiter: directed job table, randomized round-robin
// traffic against a pending-set model, and hand-written timeout/reset sequences.
module tb_sha256_job_arbiter;
   localparam int N = 4;
   localparam logic [255:0] IV  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [255:0] ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   typedef struct {
      logic [3:0] raise;
      logic [3:0] late;
      int         c;
      int         rd;
      int         grant;
      bit         err;
      bit         stub;
   } vec_t;

   logic         clk;
   logic         reset_n;
   logic [511:0] blk [N];
   logic [255:0] sd  [N];
   logic [511:0] abc_blk;
   int           checks;
   int           errors;
   int           core_cycles;
   bit           stub;
   vec_t         vecs [7];

   sha256_job_arbiter_if #(.NUM_REQ(N)) bus ();

   sha256_job_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      for (int r = 0; r < N; r++) begin
         bus.req_block[r*512 +: 512] = blk[r];
         bus.req_seed[r*256 +: 256]  = sd[r];
      end
   end

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] b);
      logic [31:0] w [64];
      logic [31:0] v [8];
      logic [31:0] t1, t2, s0, s1;
      logic [255:0] res;
      for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
      for (int i = 16; i < 64; i++) begin
         s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
         s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
         w[i] = w[i-16] + s0 + w[i-7] + s1;
      end
      for (int i = 0; i < 8; i++) v[i] = h[255-32*i -: 32];
      for (int i = 0; i < 64; i++) begin
         t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[i] + w[i];
         t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
         v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) res[255-32*i -: 32] = h[255-32*i -: 32] + v[i];
      return res;
   endfunction

   // Core model: goes busy the cycle after it samples start, stays busy core_cycles cycles.
   initial begin
      logic [255:0] s;
      logic [511:0] b;
      bus.core_done   = 1'b1;
      bus.core_digest = '0;
      forever begin
         @(posedge clk);
         if (bus.core_start === 1'b1 && !stub) begin
            s = bus.core_seed;
            b = bus.core_block;
            #1 bus.core_done = 1'b0;
            repeat (core_cycles) @(posedge clk);
            #1;
            bus.core_digest = sha_compress(s, b);
            bus.core_done   = 1'b1;
         end
      end
   end

   task automatic check_output(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_output({tag, "_req_ack"}, bus.req_ack, 0);
      check_output({tag, "_rsp_valid"}, bus.rsp_valid, 0);
      check_output({tag, "_rsp_error"}, bus.rsp_error, 0);
      check_output({tag, "_core_start"}, bus.core_start, 0);
      check_output({tag, "_core_seed"}, bus.core_seed, 0);
      check_output({tag, "_core_block"}, bus.core_block, 0);
      check_output({tag, "_rsp_digest"}, bus.rsp_digest, 0);
   endtask

   // One complete job: grant, start pulse, response latency, optional backpressure, handshake.
   task automatic apply_stimulus(input int g, input bit exp_err, input logic [255:0] exp_dig,
                                 input int exp_lat, input int rd, input logic [3:0] late);
      int n;
      int starts;
      bit stable;
      logic [3:0] onehot;
      onehot = 4'b0001 << g;
      n = 0;
      while (bus.req_ack == 0 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      check_output("req_ack", bus.req_ack, onehot);
      check_output("start_with_ack", bus.core_start, 0);
      bus.req[g] = 1'b0;
      bus.req    = bus.req | late;
      @(posedge clk); #1;
      check_output("core_start", bus.core_start, 1);
      check_output("ack_pulse_width", bus.req_ack, 0);
      check_output("core_block", bus.core_block, blk[g]);
      check_output("core_seed", bus.core_seed, sd[g]);
      n = 0;
      starts = 0;
      while (bus.rsp_valid == 0 && n < 60) begin
         @(posedge clk); #1; n++;
         if (bus.core_start) starts++;
      end
      check_output("start_to_valid", n, exp_lat);
      check_output("extra_start", starts, 0);
      check_output("rsp_valid", bus.rsp_valid, onehot);
      check_output("rsp_error", bus.rsp_error, exp_err);
      check_output("rsp_digest", bus.rsp_digest, exp_dig);
      if (rd > 0) begin
         bus.rsp_ready = ~onehot;
         stable = 1'b1;
         for (int i = 0; i < rd; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid !== onehot || bus.rsp_digest !== exp_dig || bus.rsp_error !== exp_err ||
                bus.req_ack !== 4'b0 || bus.core_start !== 1'b0) stable = 1'b0;
         end
         check_output("backpressure_hold", stable, 1);
      end
      bus.rsp_ready = onehot;
      @(posedge clk); #1;
      bus.rsp_ready = '0;
      check_output("rsp_release", {bus.rsp_valid, bus.rsp_error, bus.req_ack}, 0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] time limit");
   end

   initial begin
      logic [3:0] pending;
      int mptr;
      int g;
      int c;
      int n;
      bit found;
      checks = 0;
      errors = 0;
      stub = 1'b0;
      core_cycles = 4;
      abc_blk = '0;
      abc_blk[511 -: 32] = 32'h61626380;
      abc_blk[31:0] = 32'h00000018;
      for (int r = 0; r < N; r++) begin
         blk[r] = abc_blk;
         sd[r]  = IV;
      end
      vecs[0] = '{raise: 4'b1011, late: 4'b0000, c: 5, rd: 0,  grant: 0, err: 0, stub: 0};
      vecs[1] = '{raise: 4'b0000, late: 4'b0000, c: 3, rd: 0,  grant: 1, err: 0, stub: 0};
      vecs[2] = '{raise: 4'b0000, late: 4'b0000, c: 7, rd: 0,  grant: 3, err: 0, stub: 0};
      vecs[3] = '{raise: 4'b0001, late: 4'b0010, c: 4, rd: 20, grant: 0, err: 0, stub: 0};
      vecs[4] = '{raise: 4'b0000, late: 4'b0000, c: 2, rd: 0,  grant: 1, err: 0, stub: 0};
      vecs[5] = '{raise: 4'b0100, late: 4'b0000, c: 1, rd: 3,  grant: 2, err: 1, stub: 1};
      vecs[6] = '{raise: 4'b1000, late: 4'b0000, c: 6, rd: 0,  grant: 3, err: 0, stub: 0};

      reset_n = 1'b0;
      bus.req = '0;
      bus.rsp_ready = '0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      reset_n = 1'b1;

      $display("[TB] directed job table");
      for (int i = 0; i < 7; i++) begin
         stub = vecs[i].stub;
         core_cycles = vecs[i].c;
         bus.req = bus.req | vecs[i].raise;
         apply_stimulus(vecs[i].grant, vecs[i].err, vecs[i].err ? 256'h0 : ABC,
                        vecs[i].stub ? 17 : vecs[i].c + 2, vecs[i].rd, vecs[i].late);
      end
      stub = 1'b0;

      $display("[TB] randomized round-robin traffic");
      pending = '0;
      mptr = 0;
      for (int it = 0; it < 40; it++) begin
         logic [3:0] fresh;
         fresh = (it < 28) ? 4'($urandom_range(0, 15)) : 4'b0;
         for (int r = 0; r < N; r++) begin
            if (fresh[r] && !pending[r]) begin
               for (int k = 0; k < 16; k++) blk[r][511-32*k -: 32] = $urandom();
               for (int k = 0; k < 8; k++) sd[r][255-32*k -: 32] = $urandom();
            end
         end
         pending = pending | fresh;
         if (pending != 0) begin
            bus.req = pending;
            found = 1'b0;
            g = 0;
            for (int k = 0; k < N; k++) begin
               if (!found && pending[(mptr + k) % N]) begin
                  found = 1'b1;
                  g = (mptr + k) % N;
               end
            end
            mptr = (g + 1) % N;
            pending[g] = 1'b0;
            c = $urandom_range(1, 12);
            core_cycles = c;
            apply_stimulus(g, 1'b0, sha_compress(sd[g], blk[g]), c + 2, $urandom_range(0, 3), 4'b0);
         end
      end

      $display("[TB] reset during WAIT_DONE");
      for (int r = 0; r < N; r++) begin
         blk[r] = abc_blk;
         sd[r]  = IV;
      end
      core_cycles = 3;
      bus.req = 4'b0010;
      apply_stimulus(1, 1'b0, ABC, 5, 0, 4'b0);
      core_cycles = 10;
      bus.req[2] = 1'b1;
      n = 0;
      while (bus.req_ack == 0 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      check_output("reset_job_ack", bus.req_ack, 4'b0100);
      bus.req[2] = 1'b0;
      @(posedge clk); #1;
      check_output("reset_job_start", bus.core_start, 1);
      repeat (4) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check_all_zero("midjob_reset");
      @(posedge clk); #1;
      reset_n = 1'b1;
      n = 0;
      while (!bus.core_done && n < 40) begin
         @(posedge clk); #1; n++;
      end
      check_output("core_idle_after_reset", bus.core_done, 1);
      bus.req = 4'b1010;
      core_cycles = 4;
      apply_stimulus(1, 1'b0, ABC, 6, 0, 4'b0);
      core_cycles = 2;
      apply_stimulus(3, 1'b0, ABC, 4, 0, 4'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
